// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
// Initiator-side controller for a small synchronous-read RAM/ROM with a
// one-cycle registered read. The host issues reads and writes over a
// valid/ready handshake. Read data comes back on a one-cycle response strobe.
//
// Optional feature (macro RAM_CTRL_SWEEP_EN): a sweep engine reads every
// address in turn and produces the XOR checksum of the whole memory. When the
// macro is undefined, the sweep ports remain but have no effect:
//   - sweep_start is ignored.
//   - sweep_busy, sweep_done and sweep_sum are held at zero.
//
// Parameters: AW address width (depth = 2**AW), DW data width.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       host request handshake
//   req_we/addr/wdata         request fields (we=1 write, we=0 read)
//   resp_valid/resp_data      read response pulse; data is held until the next response
//   mem_addr/we/wdata/rdata   RAM port; rdata is valid the cycle after the address
//   sweep_start               starts a checksum sweep (sampled only in IDLE)
//   sweep_busy                high while a sweep is running
//   sweep_done/sweep_sum      done pulse and checksum; the checksum is held until the next sweep
module ram_access_ctrl #(
    parameter int AW = 2,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_data,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          sweep_start,
    output logic          sweep_busy,
    output logic          sweep_done,
    output logic [DW-1:0] sweep_sum
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, SWEEP, SW_DRAIN} state_t;

    state_t        state_q, state_d;
    logic          resp_valid_q, resp_valid_d;
    logic [DW-1:0] resp_data_q, resp_data_d;
    logic          accept;

`ifdef RAM_CTRL_SWEEP_EN
    // The counter is one bit wider than the address so that the terminal
    // count (depth) can be represented without wrapping back to 0.
    localparam logic [AW:0] CNT_END = {1'b1, {AW{1'b0}}};

    logic [AW:0]   cnt_q, cnt_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] sum_q, sum_d;
    logic          done_q, done_d;
    logic          sweep_go;

    // A sweep request wins over a simultaneous host request.
    assign sweep_go  = (state_q == IDLE) && sweep_start && !rst;
    assign req_ready = (state_q == IDLE) && !sweep_start && !rst;
`else
    logic unused_sweep_start;
    assign unused_sweep_start = sweep_start;
    assign req_ready = (state_q == IDLE) && !rst;
`endif

    assign accept = req_valid && req_ready;

    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        mem_addr     = '0;
        mem_we       = 1'b0;
        mem_wdata    = '0;
`ifdef RAM_CTRL_SWEEP_EN
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        sum_d  = sum_q;
        done_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mem_addr  = req_addr;
                    mem_wdata = req_wdata;
                    mem_we    = req_we;
                    if (!req_we) begin
                        state_d = RD_WAIT;
                    end
                end
`ifdef RAM_CTRL_SWEEP_EN
                if (sweep_go) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
`endif
            end
            RD_WAIT: begin
                // The RAM presents the word addressed in the previous cycle.
                resp_valid_d = 1'b1;
                resp_data_d  = mem_rdata;
                state_d      = IDLE;
            end
`ifdef RAM_CTRL_SWEEP_EN
            SWEEP: begin
                mem_addr = cnt_q[AW-1:0];
                // The returning data lags the address by one cycle. When the
                // count is 0 there is no word in flight yet.
                if (cnt_q != '0) begin
                    acc_d = acc_q ^ mem_rdata;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == CNT_END) begin
                    state_d = SW_DRAIN;
                end
            end
            SW_DRAIN: begin
                // Absorb the word from the last address and publish the sum.
                acc_d   = acc_q ^ mem_rdata;
                sum_d   = acc_q ^ mem_rdata;
                done_d  = 1'b1;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;

`ifdef RAM_CTRL_SWEEP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            sum_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            sum_q  <= sum_d;
            done_q <= done_d;
        end
    end

    assign sweep_busy = (state_q == SWEEP) || (state_q == SW_DRAIN);
    assign sweep_done = done_q;
    assign sweep_sum  = sum_q;
`else
    assign sweep_busy = 1'b0;
    assign sweep_done = 1'b0;
    assign sweep_sum  = '0;
`endif

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl
// Directed and randomized bench for ram_access_ctrl. The bench provides a
// behavioural RAM with a registered read. Expected values come from a
// reference copy of the memory contents and from the cycle timing of each
// transaction. The sweep checks are compiled only when RAM_CTRL_SWEEP_EN is
// defined. Otherwise, the bench checks that the sweep port is inert.
module tb_ram_access_ctrl;

    localparam int AW    = 2;
    localparam int DW    = 4;
    localparam int DEPTH = 2**AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          sweep_start = 1'b0;
    logic          sweep_busy;
    logic          sweep_done;
    logic [DW-1:0] sweep_sum;

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    ram_access_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .sweep_start(sweep_start), .sweep_busy(sweep_busy),
        .sweep_done(sweep_done), .sweep_sum(sweep_sum)
    );

    // Behavioural synchronous RAM with a one-cycle registered read.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] ref_xor();
        logic [DW-1:0] s = '0;
        for (int i = 0; i < DEPTH; i++) s ^= ref_mem[i];
        return s;
    endfunction

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        @(negedge clk);
        chk("wr_ready", req_ready, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, a);
        chk("wr_mem_wdata", mem_wdata, d);
        chk("wr_no_resp", resp_valid, 0);
        ref_mem[a] = d;
        cyc();
        req_valid = 1'b0; req_we = 1'b0;
        $display("WR addr=%0d data=%h", a, d);
    endtask

    // Read at cycle N. The host holds the request through N+1, when it must
    // not be accepted. The response is expected in N+2 and must be gone in N+3.
    task automatic do_read(input logic [AW-1:0] a);
        logic [DW-1:0] e;
        e = ref_mem[a];
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = DW'($urandom);
        @(negedge clk);
        chk("rd_ready", req_ready, 1);
        chk("rd_mem_we", mem_we, 0);
        chk("rd_mem_addr", mem_addr, a);
        cyc();
        @(negedge clk);
        chk("rd_wait_ready", req_ready, 0);
        chk("rd_wait_mem_we", mem_we, 0);
        chk("rd_wait_mem_addr", mem_addr, 0);
        chk("rd_wait_resp", resp_valid, 0);
        cyc();
        req_valid = 1'b0;
        @(negedge clk);
        chk("rd_resp_valid", resp_valid, 1);
        chk("rd_resp_data", resp_data, e);
        chk("rd_n2_ready", req_ready, 1);
        cyc();
        @(negedge clk);
        chk("rd_resp_pulse", resp_valid, 0);
        chk("rd_resp_hold", resp_data, e);
        cyc();
        $display("RD addr=%0d data=%h", a, resp_data);
    endtask

    // Two reads with no gap: the second read is accepted in the same cycle as
    // the first response.
    task automatic rd_b2b(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a1;
        cyc();
        cyc();
        req_addr = a2;
        @(negedge clk);
        chk("b2b_resp1", resp_valid, 1);
        chk("b2b_data1", resp_data, ref_mem[a1]);
        chk("b2b_ready", req_ready, 1);
        chk("b2b_mem_addr", mem_addr, a2);
        cyc();
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_gap", resp_valid, 0);
        cyc();
        @(negedge clk);
        chk("b2b_resp2", resp_valid, 1);
        chk("b2b_data2", resp_data, ref_mem[a2]);
        cyc();
        $display("RD2 addr=%0d,%0d data=%h", a1, a2, resp_data);
    endtask

`ifdef RAM_CTRL_SWEEP_EN
    // Starts a sweep at cycle N. The optional read request is raised in the
    // same cycle and held until the sweep completes.
    task automatic do_sweep(input bit with_req);
        logic [DW-1:0] e;
        e = ref_xor();
        sweep_start = 1'b1;
        req_valid = with_req; req_we = 1'b0; req_addr = 2'd1;
        @(negedge clk);
        chk("sw_ready_n", req_ready, 0);
        chk("sw_mem_we_n", mem_we, 0);
        cyc();
        sweep_start = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            chk("sw_busy", sweep_busy, 1);
            chk("sw_mem_addr", mem_addr, k);
            chk("sw_mem_we", mem_we, 0);
            chk("sw_ready", req_ready, 0);
            chk("sw_done_early", sweep_done, 0);
            cyc();
        end
        @(negedge clk);
        chk("sw_drain_busy", sweep_busy, 1);
        chk("sw_drain_done", sweep_done, 0);
        cyc();
        @(negedge clk);
        chk("sw_done", sweep_done, 1);
        chk("sw_sum", sweep_sum, e);
        chk("sw_busy_end", sweep_busy, 0);
        chk("sw_ready_back", req_ready, 1);
        if (with_req) chk("sw_req_addr", mem_addr, 1);
        cyc();
        req_valid = 1'b0;
        @(negedge clk);
        chk("sw_done_pulse", sweep_done, 0);
        chk("sw_sum_hold", sweep_sum, e);
        chk("sw_after_ready", req_ready, with_req ? 0 : 1);
        cyc();
        if (with_req) begin
            @(negedge clk);
            chk("sw_req_resp", resp_valid, 1);
            chk("sw_req_data", resp_data, ref_mem[1]);
            cyc();
        end
        $display("SWEEP req=%0d sum=%h", with_req, sweep_sum);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        // Reset state.
        @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_busy", sweep_busy, 0);
        chk("rst_done", sweep_done, 0);
        chk("rst_sum", sweep_sum, 0);
        rst = 1'b0;
        cyc();

        // Write followed immediately by a read of the same address.
        do_write(2'd2, 4'hA);
        do_read(2'd2);

        // Back-to-back writes at one per cycle.
        do_write(2'd0, 4'h4);
        do_write(2'd1, 4'hC);
        do_write(2'd2, 4'h6);
        do_write(2'd3, 4'h7);
        do_read(2'd1);
        rd_b2b(2'd3, 2'd0);

`ifdef RAM_CTRL_SWEEP_EN
        do_sweep(1'b0);
        chk("sw_known_sum", sweep_sum, 4'h9);
        do_sweep(1'b1);
`else
        // The sweep port is inert: the request is accepted despite sweep_start.
        sweep_start = 1'b1;
        do_read(2'd1);
        chk("nosw_busy", sweep_busy, 0);
        chk("nosw_done", sweep_done, 0);
        chk("nosw_sum", sweep_sum, 0);
        sweep_start = 1'b0;
`endif

        // Randomized reads and writes against the reference contents.
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 1) do_write(AW'($urandom), DW'($urandom));
            else do_read(AW'($urandom));
        end
`ifdef RAM_CTRL_SWEEP_EN
        do_sweep(1'b0);
`endif

        // Reset during RD_WAIT drops the read.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 2'd3;
        cyc();
        req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rrst_resp_valid", resp_valid, 0);
        chk("rrst_resp_data", resp_data, 0);
        chk("rrst_ready", req_ready, 0);
        chk("rrst_mem_we", mem_we, 0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rrst_no_resp", resp_valid, 0);
            cyc();
        end
        $display("RST during read");

`ifdef RAM_CTRL_SWEEP_EN
        // Reset in the middle of a sweep: no done pulse afterwards.
        sweep_start = 1'b1;
        cyc();
        sweep_start = 1'b0;
        cyc();
        cyc();
        #2 rst = 1'b1;
        #1;
        chk("srst_busy", sweep_busy, 0);
        chk("srst_done", sweep_done, 0);
        chk("srst_sum", sweep_sum, 0);
        chk("srst_ready", req_ready, 0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("srst_no_done", sweep_done, 0);
            chk("srst_no_busy", sweep_busy, 0);
            cyc();
        end
        $display("RST during sweep");
`endif

        do_read(2'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
